half_to_int: RTL and testbench
==============================

Name: half_to_int

Overview:
- Sequential converter from IEEE754 binary16 (half precision) to a 16-bit two's-complement signed integer.
- It is the decode direction of the existing integer-to-half converter.
- Uses the same single-word R_I/R_O handshake, so the two blocks chain back-to-back for round-trip checks.
- Alignment uses an iterative one-bit-per-cycle shifter, so latency depends on the exponent.

Parameters:
NAN_VALUE, 16'h0000, integer result reported for NaN inputs (with err set)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  reset, synchronous and active-high
dataIn  input  16  binary16 operand {sign, exp[4:0], frac[9:0]}
R_I  input  1  request; sampled only in IDLE
dataOut  output  16  signed integer result; updated only on entry to DONE, held otherwise
R_O  output  1  registered; high for exactly the one cycle the FSM is in DONE
err  output  1  registered; valid with R_O, held until the next DONE; 1 for NaN, Inf or out-of-range

Behaviour:
- Reset values: state=IDLE, dataOut=0, R_O=0, err=0.
- Reset mid-conversion aborts the operation: no R_O pulse, all outputs return to 0.
- IDLE:
  - On R_I=1, capture dataIn, go to CLASSIFY.
  - R_I is ignored in every other state; no queuing.
- CLASSIFY (e = exp-15):
  - exp=31, frac=0 (Inf): result 0x7FFF (+) or 0x8000 (-), err=1, go to DONE.
  - exp=31, frac!=0 (NaN): result NAN_VALUE, err=1, go to DONE.
  - exp=0 (zero/subnormal): result 0, err=0, go to DONE.
  - e<0: result 0, err=0, go to DONE.
  - e>15, or e==15 except exactly -32768 (sign=1, frac=0): saturate to 0x7FFF/0x8000, err=1, go to DONE.
  - Otherwise:
    - Load acc = {1,frac} (11-bit significand) into a 16-bit magnitude register.
    - cnt=|e-10|, dir = left if e>=10 else right.
    - Go to SHIFT if cnt>0, else to APPLY_SIGN.
- SHIFT:
  - Shift acc one bit per cycle and decrement cnt.
  - Leave for APPLY_SIGN after exactly cnt shift cycles.
  - Right shifts discard bits, i.e. truncation toward zero.
- APPLY_SIGN: result = sign ? -acc : acc, mod 2^16 (-32768 path yields 0x8000); err=0; go to DONE.
- DONE: R_O=1, dataOut/err hold the result, go to IDLE; the next R_I is accepted in the following cycle.
- Latency, counting the capture edge with R_I=1 in IDLE as cycle 0:
  - Special cases: R_O high in cycle 2.
  - Normal cases: R_O high in cycle 3+|e-10|; worst case is e=0, cycle 13.

Optional Feature:
- Macro ROUND_NEAREST_EN.
- When defined:
  - Keep guard and sticky bits during right shifts.
  - Apply round-half-to-even to the magnitude in APPLY_SIGN, before negation.
  - e==-1 also takes the shift path (cnt=11): values in (0.5,1) give 1; exactly 0.5 gives 0.
  - e<-1 still gives 0.
  - Magnitudes below 1024 cannot overflow after rounding.
  - Latency formula unchanged; e=-1 gives cycle 14.
- When undefined: truncation toward zero, and e==-1 gives 0 from CLASSIFY.

Decomposition:
- Shared package (also usable by the integer-to-half block):
  - state enum {IDLE, CLASSIFY, SHIFT, APPLY_SIGN, DONE}
  - EXP_W=5, FRAC_W=10, EXP_BIAS=15
  - INT16_MAX=16'h7FFF, INT16_MIN=16'h8000
- One natural sub-module, fp16_classify: combinational decode of the captured word into is_nan, is_inf, is_zero_or_sub, unbiased exponent, significand.

Test Plan:
- 0x3C00 (1.0): dataOut 0x0001, err 0, R_O in cycle 13; 0x6400 (1024.0): 0x0400, R_O in cycle 3.
- 0xC500 (-5.0): 0xFFFB; 0xF800 (-32768.0): 0x8000, err 0.
- 0x7800 (32768.0): 0x7FFF, err 1; 0x7BFF: 0x7FFF, err 1; 0x7C00: 0x7FFF, err 1; 0xFC00: 0x8000, err 1; 0x7E00: 0x0000, err 1, R_O in cycle 2.
- 0x3E00 (1.5), 0x4100 (2.5), 0xBE00 (-1.5):
  - truncating build: 0x0001, 0x0002, 0xFFFF;
  - ROUND_NEAREST_EN build: 0x0002, 0x0002, 0xFFFE.
  - Also 0x3800 (0.5) gives 0 in both builds; 0x3A00 (0.75) gives 0 truncating, 1 rounding.
- R_I held high continuously: one conversion per IDLE visit, inputs changed mid-flight ignored, back-to-back R_O pulses separated by at least one IDLE cycle.
- Reset asserted during SHIFT: no R_O; dataOut=0 and err=0 on the next cycle; a new request then converts correctly.

Source files
------------

// File: rtl/half_to_int_pkg.sv
// Shared definitions for the binary16 <-> int16 converter pair.
// Holds the sequencer state encoding, binary16 field widths and the
// int16 saturation limits so the integer-to-half block can reuse them.
package half_to_int_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        SHIFT,
        APPLY_SIGN,
        DONE
    } state_t;

    localparam int unsigned EXP_W    = 5;
    localparam int unsigned FRAC_W   = 10;
    localparam int unsigned EXP_BIAS = 15;
    localparam int unsigned INT_W    = 16;
    localparam int unsigned SIG_W    = FRAC_W + 1;
    localparam int unsigned EXPU_W   = EXP_W + 1;
    localparam int unsigned CNT_W    = 4;

    localparam logic [INT_W-1:0] INT16_MAX = 16'h7FFF;
    localparam logic [INT_W-1:0] INT16_MIN = 16'h8000;

    // Saturated int16 value for the given sign.
    function automatic logic [INT_W-1:0] saturate(input logic sign);
        return sign ? INT16_MIN : INT16_MAX;
    endfunction

endpackage

// File: rtl/half_to_int_fp16_classify.sv
// fp16_classify: combinational field decode of a binary16 word.
// Ports:
//   word           - binary16 operand {sign, exp[4:0], frac[9:0]}
//   sign           - sign bit
//   is_nan         - exp all ones, frac non-zero
//   is_inf         - exp all ones, frac zero
//   is_zero_or_sub - exp zero (zero or subnormal)
//   frac_zero      - fraction field is zero
//   exp_unb        - unbiased exponent exp-15 (signed)
//   signif         - significand with hidden one {1, frac}
module fp16_classify
    import half_to_int_pkg::*;
(
    input  logic [INT_W-1:0]         word,
    output logic                     sign,
    output logic                     is_nan,
    output logic                     is_inf,
    output logic                     is_zero_or_sub,
    output logic                     frac_zero,
    output logic signed [EXPU_W-1:0] exp_unb,
    output logic [SIG_W-1:0]         signif
);

    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac_f;

    assign sign           = word[INT_W-1];
    assign exp_f          = word[INT_W-2 -: EXP_W];
    assign frac_f         = word[FRAC_W-1:0];
    assign frac_zero      = (frac_f == '0);
    assign is_nan         = (exp_f == '1) && !frac_zero;
    assign is_inf         = (exp_f == '1) && frac_zero;
    assign is_zero_or_sub = (exp_f == '0);
    assign exp_unb        = signed'(EXPU_W'({1'b0, exp_f}) - EXPU_W'(EXP_BIAS));
    assign signif         = {1'b1, frac_f};

endmodule

// File: rtl/half_to_int.sv
// half_to_int: sequential binary16 -> signed int16 converter.
// Alignment is done by a one-bit-per-cycle shifter, so latency depends on
// the exponent. Default build truncates toward zero; define
// ROUND_NEAREST_EN for round-half-to-even (also routes e==-1 through the
// shifter so values in (0.5,1) round to 1).
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   dataIn  - binary16 operand, captured in IDLE when R_I=1
//   R_I     - request, only sampled in IDLE
//   dataOut - int16 result, updated on entry to DONE, held otherwise
//   R_O     - one-cycle pulse while in DONE
//   err     - NaN / Inf / out-of-range flag, valid with R_O, held
module half_to_int
    import half_to_int_pkg::*;
#(
    parameter logic [15:0] NAN_VALUE = 16'h0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] dataIn,
    input  logic             R_I,
    output logic [INT_W-1:0] dataOut,
    output logic             R_O,
    output logic             err
);

    localparam logic signed [EXPU_W-1:0] E_ALIGN   = 6'sd10;
    localparam logic signed [EXPU_W-1:0] E_INT_MAX = 6'sd15;
`ifdef ROUND_NEAREST_EN
    localparam logic signed [EXPU_W-1:0] E_MIN     = -6'sd1;
`else
    localparam logic signed [EXPU_W-1:0] E_MIN     = 6'sd0;
`endif

    state_t             state;
    logic [INT_W-1:0]   word_q;
    logic [INT_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               dir_left;
`ifdef ROUND_NEAREST_EN
    logic               guard;
    logic               sticky;
`endif

    logic                     c_sign;
    logic                     c_nan;
    logic                     c_inf;
    logic                     c_zero;
    logic                     c_frac_zero;
    logic signed [EXPU_W-1:0] c_exp;
    logic [SIG_W-1:0]         c_signif;

    logic                     too_big;
    logic [CNT_W-1:0]         shift_cnt;
    logic [INT_W-1:0]         mag;

    fp16_classify u_classify (
        .word           (word_q),
        .sign           (c_sign),
        .is_nan         (c_nan),
        .is_inf         (c_inf),
        .is_zero_or_sub (c_zero),
        .frac_zero      (c_frac_zero),
        .exp_unb        (c_exp),
        .signif         (c_signif)
    );

    // Out of int16 range; exactly -32768 is the one e==15 value that fits.
    assign too_big = (c_exp > E_INT_MAX) ||
                     ((c_exp == E_INT_MAX) && !(c_sign && c_frac_zero));

    // Shift distance |e-10| between the significand's LSB and the unit bit.
    always_comb begin
        shift_cnt = '0;
        if (c_exp >= E_ALIGN) shift_cnt = CNT_W'(c_exp - E_ALIGN);
        else                  shift_cnt = CNT_W'(E_ALIGN - c_exp);
    end

    // Final magnitude, rounded half-to-even before negation when enabled.
    always_comb begin
        mag = acc;
`ifdef ROUND_NEAREST_EN
        mag = acc + INT_W'(guard & (sticky | acc[0]));
`endif
    end

    // Conversion sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            word_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            dir_left <= 1'b0;
            dataOut  <= '0;
            R_O      <= 1'b0;
            err      <= 1'b0;
`ifdef ROUND_NEAREST_EN
            guard    <= 1'b0;
            sticky   <= 1'b0;
`endif
        end else begin
            R_O <= 1'b0;
            case (state)
                IDLE: begin
                    if (R_I) begin
                        word_q <= dataIn;
                        state  <= CLASSIFY;
                    end
                end

                CLASSIFY: begin
`ifdef ROUND_NEAREST_EN
                    guard  <= 1'b0;
                    sticky <= 1'b0;
`endif
                    if (c_nan) begin
                        dataOut <= NAN_VALUE;
                        err     <= 1'b1;
                        R_O     <= 1'b1;
                        state   <= DONE;
                    end else if (c_inf || (!c_zero && too_big)) begin
                        dataOut <= saturate(c_sign);
                        err     <= 1'b1;
                        R_O     <= 1'b1;
                        state   <= DONE;
                    end else if (c_zero || (c_exp < E_MIN)) begin
                        dataOut <= '0;
                        err     <= 1'b0;
                        R_O     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc      <= INT_W'(c_signif);
                        cnt      <= shift_cnt;
                        dir_left <= (c_exp >= E_ALIGN);
                        state    <= (shift_cnt != '0) ? SHIFT : APPLY_SIGN;
                    end
                end

                SHIFT: begin
                    if (dir_left) begin
                        acc <= acc << 1;
                    end else begin
                        acc <= acc >> 1;
`ifdef ROUND_NEAREST_EN
                        guard  <= acc[0];
                        sticky <= sticky | guard;
`endif
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= APPLY_SIGN;
                end

                // Two's-complement negate mod 2^16; -32768 maps to 0x8000.
                APPLY_SIGN: begin
                    dataOut <= c_sign ? (~mag + INT_W'(1)) : mag;
                    err     <= 1'b0;
                    R_O     <= 1'b1;
                    state   <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_to_int.sv
// Scoreboard bench for half_to_int: directed binary16 vectors with
// hand-computed int16 results, error flags and latencies.
module tb_half_to_int;

    logic        clk;
    logic        reset;
    logic [15:0] dataIn;
    logic        R_I;
    logic [15:0] dataOut;
    logic        R_O;
    logic        err;

    typedef struct {
        logic [15:0] din;
        logic [15:0] dout;
        logic        err;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    half_to_int dut (
        .clk     (clk),
        .reset   (reset),
        .dataIn  (dataIn),
        .R_I     (R_I),
        .dataOut (dataOut),
        .R_O     (R_O),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pops the scoreboard whenever the DUT presents a result.
    task automatic monitor();
        logic prev_ro;
        exp_t e;
        prev_ro = 1'b0;
        forever begin
            @(negedge clk);
            if (R_O === 1'b1) begin
                checks++;
                if (prev_ro) begin
                    errors++;
                    $display("FAIL ro_gap: R_O high on consecutive cycles at cyc %0d", cyc);
                end
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ro: dataOut=%h err=%b at cyc %0d", dataOut, err, cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (dataOut !== e.dout) begin
                        errors++;
                        $display("FAIL data[%h]: got %h expected %h", e.din, dataOut, e.dout);
                    end
                    checks++;
                    if (err !== e.err) begin
                        errors++;
                        $display("FAIL err[%h]: got %b expected %b", e.din, err, e.err);
                    end
                    checks++;
                    if (cyc - e.issue != e.lat) begin
                        errors++;
                        $display("FAIL latency[%h]: got %0d expected %0d", e.din, cyc - e.issue, e.lat);
                    end
                    done_cnt++;
                end
            end
            prev_ro = (R_O === 1'b1);
        end
    endtask

    // Waits (bounded) until done_cnt reaches target.
    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            errors++;
            $display("FAIL timeout[%s]: done %0d expected %0d", name, done_cnt, target);
            while (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    // Issues one request from IDLE and waits for its result.
    task automatic convert(input logic [15:0] din, input logic [15:0] dout,
                           input logic e_err, input int lat);
        exp_t e;
        int   target;
        target = done_cnt + 1;
        @(negedge clk);
        dataIn  = din;
        R_I     = 1'b1;
        e.din   = din;
        e.dout  = dout;
        e.err   = e_err;
        e.lat   = lat;
        e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        R_I    = 1'b0;
        dataIn = 16'hDEAD;
        wait_done(target, "convert");
    endtask

    initial begin
        exp_t e;
        int   target;

        reset  = 1'b1;
        R_I    = 1'b0;
        dataIn = 16'h0000;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        checks++;
        if (dataOut !== 16'h0000 || R_O !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: dataOut=%h R_O=%b err=%b expected 0000 0 0", dataOut, R_O, err);
        end
        reset = 1'b0;

        // Normal conversions
        convert(16'h3C00, 16'h0001, 1'b0, 13);
        convert(16'h6400, 16'h0400, 1'b0, 3);
        convert(16'hC500, 16'hFFFB, 1'b0, 11);
        convert(16'hF800, 16'h8000, 1'b0, 8);
        convert(16'h5640, 16'h0064, 1'b0, 7);
        convert(16'h77FF, 16'h7FF0, 1'b0, 7);
        // Specials and range limits
        convert(16'h7800, 16'h7FFF, 1'b1, 2);
        convert(16'h7BFF, 16'h7FFF, 1'b1, 2);
        convert(16'hF801, 16'h8000, 1'b1, 2);
        convert(16'h7C00, 16'h7FFF, 1'b1, 2);
        convert(16'hFC00, 16'h8000, 1'b1, 2);
        convert(16'h7E00, 16'h0000, 1'b1, 2);
        convert(16'h0000, 16'h0000, 1'b0, 2);
        convert(16'h8001, 16'h0000, 1'b0, 2);
        convert(16'h3400, 16'h0000, 1'b0, 2);
        // Fractional values
`ifdef ROUND_NEAREST_EN
        convert(16'h3E00, 16'h0002, 1'b0, 13);
        convert(16'h4100, 16'h0002, 1'b0, 12);
        convert(16'hBE00, 16'hFFFE, 1'b0, 13);
        convert(16'h3800, 16'h0000, 1'b0, 14);
        convert(16'h3A00, 16'h0001, 1'b0, 14);
`else
        convert(16'h3E00, 16'h0001, 1'b0, 13);
        convert(16'h4100, 16'h0002, 1'b0, 12);
        convert(16'hBE00, 16'hFFFF, 1'b0, 13);
        convert(16'h3800, 16'h0000, 1'b0, 2);
        convert(16'h3A00, 16'h0000, 1'b0, 2);
`endif

        // R_I held high: second capture happens in the IDLE cycle after DONE
        target = done_cnt + 2;
        @(negedge clk);
        dataIn  = 16'h6400;
        R_I     = 1'b1;
        e.din   = 16'h6400; e.dout = 16'h0400; e.err = 1'b0; e.lat = 3; e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        dataIn  = 16'h4500;
        e.din   = 16'h4500; e.dout = 16'h0005; e.err = 1'b0; e.lat = 11; e.issue = cyc + 3;
        sb.push_back(e);
        repeat (4) @(negedge clk);
        R_I    = 1'b0;
        dataIn = 16'hDEAD;
        wait_done(target, "held_ri");

        // Reset during SHIFT aborts without a result
        convert(16'h7C00, 16'h7FFF, 1'b1, 2);
        @(negedge clk);
        dataIn = 16'h3C00;
        R_I    = 1'b1;
        @(negedge clk);
        R_I    = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dataOut !== 16'h0000 || err !== 1'b0 || R_O !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: dataOut=%h err=%b R_O=%b expected 0000 0 0", dataOut, err, R_O);
        end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        convert(16'hC500, 16'hFFFB, 1'b0, 11);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d results outstanding, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
